// File: rtl/router_pkg.sv
// Shared router types and constants: flit geometry, port indices, input handshake states.
package router_pkg;

   localparam int FLIT_WIDTH = 32;
   localparam int FIFO_DEPTH = 4;

   localparam int N = 0;
   localparam int E = 1;
   localparam int W = 2;
   localparam int S = 3;
   localparam int L = 4;
   localparam int NUM_PORTS = 5;

   typedef enum logic {
      HS_IDLE = 1'b0,
      HS_ACK  = 1'b1
   } hs_state_t;

   typedef logic [FIFO_DEPTH-1:0] onehot_ptr_t;

   function automatic onehot_ptr_t onehot_rotl(input onehot_ptr_t p);
      return {p[FIFO_DEPTH-2:0], p[FIFO_DEPTH-1]};
   endfunction

endpackage

// File: rtl/fifo_handshake_ctrl.sv
// RTS/CTS acceptor: write_en is combinational in IDLE, CTS is a registered one-cycle pulse after each accept.
// A full buffer holds the FSM in IDLE with CTS low, so upstream keeps DRTS asserted until space frees up.
module fifo_handshake_ctrl
   import router_pkg::*;
(
   input  logic clk,
   input  logic rst,
   input  logic drts,
   input  logic full,
   output logic cts,
   output logic write_en
);

   hs_state_t state;

   assign write_en = (state == HS_IDLE) & drts & ~full;

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= HS_IDLE;
         cts   <= 1'b0;
      end else begin
         case (state)
            HS_IDLE: begin
               if (drts && !full) begin
                  state <= HS_ACK;
                  cts   <= 1'b1;
               end else begin
                  state <= HS_IDLE;
                  cts   <= 1'b0;
               end
            end
            // The ACK cycle never writes, which gives the upstream time to drop DRTS.
            HS_ACK: begin
               state <= HS_IDLE;
               cts   <= 1'b0;
            end
            default: begin
               state <= HS_IDLE;
               cts   <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: rtl/router_input_fifo.sv
// Per-port router input buffer: one-hot circular store, head flit combinational at Data_out, 1-cycle RX-to-head latency.
// Backpressure is full blocking the RTS/CTS accept; any output grant pops one flit, grants on empty are ignored.
module router_input_fifo
   import router_pkg::*;
#(
   parameter int DATA_WIDTH = FLIT_WIDTH,
   parameter int DEPTH      = FIFO_DEPTH
)
(
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    DRTS,
   output logic                    CTS,
   input  logic [DATA_WIDTH-1:0]   RX,
   input  logic                    read_en_N,
   input  logic                    read_en_E,
   input  logic                    read_en_W,
   input  logic                    read_en_S,
   input  logic                    read_en_L,
   output logic [DATA_WIDTH-1:0]   Data_out,
   output logic                    empty,
   output logic                    full,
   output logic [$clog2(DEPTH):0]  count
);

   localparam int CW = $clog2(DEPTH) + 1;
   localparam logic [DEPTH-1:0] PTR_INIT = {{(DEPTH-1){1'b0}}, 1'b1};

   logic [DATA_WIDTH-1:0] mem [DEPTH];
   logic [DEPTH-1:0]      write_ptr;
   logic [DEPTH-1:0]      read_ptr;
   logic [NUM_PORTS-1:0]  grant;
   logic                  read_req;
   logic                  read_fire;
   logic                  write_en;

   assign grant[N] = read_en_N;
   assign grant[E] = read_en_E;
   assign grant[W] = read_en_W;
   assign grant[S] = read_en_S;
   assign grant[L] = read_en_L;

   assign read_req  = |grant;
   assign read_fire = read_req & ~empty;

   assign empty = (count == '0);
   assign full  = (count == CW'(DEPTH));

   fifo_handshake_ctrl u_hs (
      .clk      (clk),
      .rst      (rst),
      .drts     (DRTS),
      .full     (full),
      .cts      (CTS),
      .write_en (write_en)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else begin
         for (int i = 0; i < DEPTH; i++) begin
            if (write_en && write_ptr[i]) begin
               mem[i] <= RX;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         write_ptr <= PTR_INIT;
         read_ptr  <= PTR_INIT;
      end else begin
         if (write_en) begin
            write_ptr <= {write_ptr[DEPTH-2:0], write_ptr[DEPTH-1]};
         end
         if (read_fire) begin
            read_ptr <= {read_ptr[DEPTH-2:0], read_ptr[DEPTH-1]};
         end
      end
   end

   // Write and pop in the same cycle leave occupancy unchanged.
   always_ff @(posedge clk) begin
      if (rst) begin
         count <= '0;
      end else begin
         case ({write_en, read_fire})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   always_comb begin
      Data_out = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (read_ptr[i]) begin
            Data_out = Data_out | mem[i];
         end
      end
   end

   ptr_onehot_a: assert property (@(posedge clk) disable iff (rst)
      $onehot(read_ptr) && $onehot(write_ptr));
   count_range_a: assert property (@(posedge clk) disable iff (rst)
      count <= CW'(DEPTH));

endmodule

// File: tb/tb_router_input_fifo.sv
// Directed test-plan sequences then random traffic, checked every cycle against a queue-based reference model.
module tb_router_input_fifo;

   localparam int DW = 32;
   localparam int DEPTH = 4;

   logic          clk = 1'b0;
   logic          rst;
   logic          DRTS;
   logic          CTS;
   logic [DW-1:0] RX;
   logic          read_en_N, read_en_E, read_en_W, read_en_S, read_en_L;
   logic [DW-1:0] Data_out;
   logic          empty, full;
   logic [2:0]    count;

   int total = 0;
   int bad   = 0;

   router_input_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
      .clk       (clk),
      .rst       (rst),
      .DRTS      (DRTS),
      .CTS       (CTS),
      .RX        (RX),
      .read_en_N (read_en_N),
      .read_en_E (read_en_E),
      .read_en_W (read_en_W),
      .read_en_S (read_en_S),
      .read_en_L (read_en_L),
      .Data_out  (Data_out),
      .empty     (empty),
      .full      (full),
      .count     (count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   // Reference model: the buffer is a plain queue; an accepted flit blocks acceptance for one cycle.
   logic [DW-1:0] m_q[$];
   logic [DW-1:0] pop_log[$];
   bit            m_ack   = 1'b0;
   bit            m_zero  = 1'b1;
   bit            m_valid = 1'b0;

   always @(negedge clk) begin
      bit wr, rd, req;
      if (m_valid) begin
         chk("cts", {31'b0, CTS}, {31'b0, m_ack});
         chk("count", {29'b0, count}, m_q.size());
         chk("empty", {31'b0, empty}, {31'b0, (m_q.size() == 0)});
         chk("full", {31'b0, full}, {31'b0, (m_q.size() == DEPTH)});
         if (m_q.size() > 0)
            chk("head", Data_out, m_q[0]);
         else if (m_zero)
            chk("data_after_reset", Data_out, '0);
      end
      if (rst) begin
         m_q.delete();
         m_ack   = 1'b0;
         m_zero  = 1'b1;
         m_valid = 1'b1;
      end else if (m_valid) begin
         req = read_en_N | read_en_E | read_en_W | read_en_S | read_en_L;
         wr  = !m_ack && DRTS && (m_q.size() < DEPTH);
         rd  = req && (m_q.size() > 0);
         if (rd) begin
            pop_log.push_back(Data_out);
            void'(m_q.pop_front());
         end
         if (wr) begin
            m_q.push_back(RX);
            m_zero = 1'b0;
         end
         m_ack = wr;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Upstream agent: raise DRTS, drop it in the cycle CTS is seen; optionally hit reset in that same cycle.
   task automatic send(input logic [DW-1:0] v, input bit rst_on_cts);
      bit got;
      got  = 1'b0;
      DRTS = 1'b1;
      RX   = v;
      for (int i = 0; i < 20 && !got; i++) begin
         tick();
         if (CTS) got = 1'b1;
      end
      DRTS = 1'b0;
      if (got && rst_on_cts) rst = 1'b1;
      if (!got) begin
         total++;
         bad++;
         $display("FAIL send_timeout: flit %h got no CTS, expected CTS within 20 cycles", v);
      end
   endtask

   initial begin
      logic [DW-1:0] exp_pops [5];
      bit got;
      exp_pops = '{32'h11, 32'h22, 32'h33, 32'h44, 32'h55};

      rst = 1'b1; DRTS = 1'b0; RX = '0;
      read_en_N = 0; read_en_E = 0; read_en_W = 0; read_en_S = 0; read_en_L = 0;
      tick(); tick();
      rst = 1'b0;
      tick();
      chk("rst_count", {29'b0, count}, 32'd0);
      chk("rst_empty", {31'b0, empty}, 32'd1);
      chk("rst_data", Data_out, 32'd0);
      chk("rst_cts", {31'b0, CTS}, 32'd0);

      send(32'hA5A5_0001, 1'b0);
      chk("single_count", {29'b0, count}, 32'd1);
      chk("single_data", Data_out, 32'hA5A5_0001);
      tick();
      read_en_E = 1; tick(); read_en_E = 0;
      chk("single_drained", {29'b0, count}, 32'd0);
      chk("single_empty", {31'b0, empty}, 32'd1);

      pop_log.delete();
      send(32'h11, 1'b0); send(32'h22, 1'b0); send(32'h33, 1'b0); send(32'h44, 1'b0);
      DRTS = 1'b1; RX = 32'h55;
      tick(); tick(); tick();
      chk("full_flag", {31'b0, full}, 32'd1);
      chk("full_count", {29'b0, count}, 32'd4);
      chk("full_no_cts", {31'b0, CTS}, 32'd0);
      read_en_L = 1; tick(); read_en_L = 0;
      got = 1'b0;
      for (int i = 0; i < 10 && !got; i++) begin
         tick();
         if (CTS) got = 1'b1;
      end
      DRTS = 1'b0;
      chk("full_retry_cts", {31'b0, got}, 32'd1);
      read_en_L = 1; repeat (4) tick(); read_en_L = 0;
      tick();
      chk("drain_len", pop_log.size(), 32'd5);
      for (int i = 0; i < 5 && i < pop_log.size(); i++)
         chk("drain_order", pop_log[i], exp_pops[i]);

      read_en_S = 1; tick(); read_en_S = 0;
      chk("read_empty", {29'b0, count}, 32'd0);

      send(32'h1, 1'b0); tick();
      send(32'h2, 1'b0); tick();
      read_en_N = 1; read_en_W = 1; tick(); read_en_N = 0; read_en_W = 0;
      chk("multi_grant", {29'b0, count}, 32'd1);

      send(32'h3, 1'b0); tick();
      DRTS = 1'b1; RX = 32'h4; read_en_N = 1;
      tick();
      DRTS = 1'b0; read_en_N = 0;
      chk("simul_count", {29'b0, count}, 32'd2);
      chk("simul_head", Data_out, 32'h3);
      tick();

      send(32'h5, 1'b1);
      chk("pre_rst_count", {29'b0, count}, 32'd3);
      tick();
      rst = 1'b0;
      chk("midrst_count", {29'b0, count}, 32'd0);
      chk("midrst_cts", {31'b0, CTS}, 32'd0);
      chk("midrst_data", Data_out, 32'd0);
      send(32'h6, 1'b0);
      chk("post_rst_head", Data_out, 32'h6);
      tick();

      for (int c = 0; c < 800; c++) begin
         rst       = ($urandom_range(0, 99) == 0);
         DRTS      = $urandom_range(0, 1);
         RX        = $urandom;
         read_en_N = ($urandom_range(0, 7) == 0);
         read_en_E = ($urandom_range(0, 7) == 0);
         read_en_W = ($urandom_range(0, 7) == 0);
         read_en_S = ($urandom_range(0, 7) == 0);
         read_en_L = ($urandom_range(0, 7) == 0);
         tick();
      end
      rst = 0; DRTS = 0;
      read_en_N = 0; read_en_E = 0; read_en_W = 0; read_en_S = 0; read_en_L = 0;
      tick(); tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
